// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants, FSM state type and round helper functions.
package sha1_pkg;

  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  localparam logic [31:0] K [0:3] = '{32'h5a827999, 32'h6ed9eba1,
                                      32'h8f1bbcdc, 32'hca62c1d6};

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Rotate left by n (n in 0..31).
  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Round function: Ch, Parity, Maj, Parity over the four 20-round groups.
  function automatic logic [31:0] f_sel(input logic [6:0]  t,
                                        input logic [31:0] b,
                                        input logic [31:0] c,
                                        input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] k_sel(input logic [6:0] t);
    if (t < 7'd20)      return K[0];
    else if (t < 7'd40) return K[1];
    else if (t < 7'd60) return K[2];
    else                return K[3];
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round; chained UNROLL deep inside the core.
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] w,
  input  logic [6:0]  t,
  output logic [31:0] a_n,
  output logic [31:0] b_n,
  output logic [31:0] c_n,
  output logic [31:0] d_n,
  output logic [31:0] e_n
);

  assign a_n = rotl(a, 5) + f_sel(t, b, c, d) + e + k_sel(t) + w;
  assign b_n = a;
  assign c_n = rotl(b, 30);
  assign d_n = c;
  assign e_n = d;

endmodule

// File: rtl/sha1_core_unrolled.sv
// SHA-1 compression engine, UNROLL rounds per clock, valid/ready input,
// back-to-back acceptance in DONE and forwarded chaining value.
module sha1_core_unrolled
  import sha1_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] data_i,
  input  logic [159:0] cv_i,
  input  logic         use_prev_cv,
  output logic         busy,
  output logic         out_valid,
  output logic [159:0] cv_next
);

  localparam int NCYC = 80 / UNROLL;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5 ||
        UNROLL == 8 || UNROLL == 10 || UNROLL == 16)) begin : g_bad_unroll
    $error("sha1_core_unrolled: UNROLL must be one of 1,2,4,5,8,10,16");
  end

  state_t         state_q, state_d;
  logic [6:0]     rcnt_q;
  logic [6:0]     t_base;
  logic [31:0]    sched_q [0:15];
  logic [31:0]    ext     [0:15+UNROLL];
  logic [159:0]   abcde_q, cv_used_q, cv_next_q;
  logic [159:0]   sum, cv_sel, rnd_out;
  logic           accept;

  // Outputs depend only on state and rst, never on in_valid.
  assign in_ready  = !rst && (state_q != ROUND);
  assign busy      = !rst && (state_q == ROUND);
  assign out_valid = !rst && (state_q == DONE);
  assign cv_next   = cv_next_q;
  assign accept    = in_valid && in_ready;
  assign t_base    = rcnt_q * 7'(UNROLL);

  // A DONE-cycle accept chains from the sum being written, not stale cv_next.
  assign cv_sel = !use_prev_cv      ? cv_i :
                  (state_q == DONE) ? sum  : cv_next_q;

  // Extend the 16-word window by UNROLL freshly scheduled words.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = sched_q[i];
    for (int i = 16; i < 16 + UNROLL; i++)
      ext[i] = rotl(ext[i-3] ^ ext[i-8] ^ ext[i-14] ^ ext[i-16], 1);
  end

  // Five independent mod-2^32 feed-forward adds.
  always_comb begin
    sum = '0;
    for (int k = 0; k < 5; k++)
      sum[32*k +: 32] = cv_used_q[32*k +: 32] + abcde_q[32*k +: 32];
  end

  // Cascade of UNROLL rounds; round j of this cycle is t_base + j.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [159:0] st_in, st_out;
    logic [6:0]   t_j;
    if (j == 0) begin : g_first
      assign st_in = abcde_q;
    end else begin : g_next
      assign st_in = g_rnd[j-1].st_out;
    end
    assign t_j = t_base + 7'(j);
    sha1_round u_round (
      .a  (st_in[159:128]), .b  (st_in[127:96]), .c  (st_in[95:64]),
      .d  (st_in[63:32]),   .e  (st_in[31:0]),
      .w  (ext[j]),         .t  (t_j),
      .a_n(st_out[159:128]), .b_n(st_out[127:96]), .c_n(st_out[95:64]),
      .d_n(st_out[63:32]),   .e_n(st_out[31:0])
    );
  end
  assign rnd_out = g_rnd[UNROLL-1].st_out;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (rcnt_q == 7'(NCYC - 1)) state_d = DONE;
      DONE:    state_d = accept ? ROUND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, round counter, working variables, schedule and chaining registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      cv_next_q <= IV;
    end else begin
      state_q <= state_d;
      if (state_q == DONE) cv_next_q <= sum;
      if (accept) begin
        for (int i = 0; i < 16; i++) sched_q[i] <= data_i[511-32*i -: 32];
        cv_used_q <= cv_sel;
        abcde_q   <= cv_sel;
        rcnt_q    <= '0;
      end else if (state_q == ROUND) begin
        for (int i = 0; i < 16; i++) sched_q[i] <= ext[i+UNROLL];
        abcde_q <= rnd_out;
        rcnt_q  <= rcnt_q + 7'd1;
      end
    end
  end

endmodule
